sd_spi_host_cmd: RTL

- Host-side SPI-mode SD command engine; it is the initiator that the SD card model answers.
- Serialises one 48-bit command frame onto the card input, hunts for the R1 response, and for single-block reads (CMD17) also hunts for the 0xFE start token.
- On a read it streams 512 data bytes, then captures the 16-bit CRC.
- Sits under the init/read sequencers; they issue one request at a time and consume done/resp/data.

---
 rtl/sd_pkg.sv | 38 +++
 rtl/sd_crc7.sv | 24 ++
 rtl/sd_spi_host_cmd.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD host command engine: state encoding,
// command indices, frame/block geometry and the frame builder.
package sd_pkg;

  localparam int unsigned FRAME_BITS    = 48;
  localparam int unsigned CRC_COVER     = 40;
  localparam int unsigned DATA_CRC_BITS = 16;
  localparam int unsigned TAIL_CYCLES   = 8;
  localparam int unsigned BLK_BYTES_DEF = 512;
  localparam int unsigned NCR_MAX_DEF   = 64;
  localparam int unsigned TOKEN_MAX_DEF = 8192;

  localparam logic [7:0] SD_TOKEN_START = 8'hFE;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_R1,
    RECV_R1,
    WAIT_TOKEN,
    RECV_DATA,
    RECV_CRC,
    TAIL
  } sd_state_t;

  function automatic logic [FRAME_BITS-1:0] sd_frame(input logic [5:0]  idx,
                                                     input logic [31:0] arg,
                                                     input logic [6:0]  crc);
    return {2'b01, idx, arg, crc, 1'b1};
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1, init 0) for SD command frames.
module sd_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb_c;
  assign fb_c = din ^ crc[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb_c ? 7'h09 : 7'h00);
    end
  end

endmodule

// File: rtl/sd_spi_host_cmd.sv
// SPI-mode SD host command engine: sends one 48-bit frame, collects R1 and,
// for block reads, the data block and its CRC. SD_CMD_CRC7_EN computes CRC7 in-line.
module sd_spi_host_cmd
  import sd_pkg::*;
#(
  parameter int unsigned NCR_MAX   = NCR_MAX_DEF,
  parameter int unsigned TOKEN_MAX = TOKEN_MAX_DEF,
  parameter int unsigned BLK_BYTES = BLK_BYTES_DEF
) (
  input  logic        SD_CLK,
  input  logic        rst_n,
  input  logic        cmd_req,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        cmd_rd,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp_r1,
  output logic        resp_err,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic [15:0] rd_crc,
  output logic        SD_CS,
  output logic        SD_MOSI,
  input  logic        SD_MISO
);

  localparam int unsigned WAIT_W = $clog2(TOKEN_MAX) + 1;

  sd_state_t             state;
  logic [FRAME_BITS-1:0] frame;
  logic                  rd_cmd;
  logic [5:0]            bit_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [7:0]            shift;
  logic [9:0]            byte_cnt;
  logic                  mosi_bit;
  logic [7:0]            shift_in_c;
  logic                  tx_bit_c;

  assign shift_in_c = {shift[6:0], SD_MISO};

`ifdef SD_CMD_CRC7_EN
  // CRC accumulates over bits 47..8 and then replaces the latched crc field.
  logic [6:0] crc7;
  logic       crc_en_c;
  logic       crc_clr_c;
  assign crc_en_c  = (state == SEND) && (bit_cnt >= 6'd8);
  assign crc_clr_c = (state == IDLE);

  sd_crc7 u_crc7 (
    .clk   (SD_CLK),
    .rst_n (rst_n),
    .clr   (crc_clr_c),
    .en    (crc_en_c),
    .din   (frame[bit_cnt]),
    .crc   (crc7)
  );

  assign tx_bit_c = (bit_cnt >= 6'd1 && bit_cnt <= 6'd7) ? crc7[3'(bit_cnt - 6'd1)]
                                                         : frame[bit_cnt];
`else
  assign tx_bit_c = frame[bit_cnt];
`endif

  // Card samples on posedge, so the host launches MOSI on the falling edge.
  always_ff @(negedge SD_CLK or negedge rst_n) begin
    if (!rst_n) SD_MOSI <= 1'b1;
    else        SD_MOSI <= mosi_bit;
  end

  always_ff @(posedge SD_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      frame    <= '0;
      rd_cmd   <= 1'b0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      shift    <= '1;
      byte_cnt <= '0;
      mosi_bit <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      resp_r1  <= 8'hFF;
      resp_err <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_crc   <= '0;
      SD_CS    <= 1'b1;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      mosi_bit <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_req) begin
            frame    <= sd_frame(cmd_idx, cmd_arg, cmd_crc);
            rd_cmd   <= cmd_rd;
            busy     <= 1'b1;
            SD_CS    <= 1'b0;
            bit_cnt  <= 6'(FRAME_BITS - 1);
            resp_r1  <= 8'hFF;
            resp_err <= 1'b0;
            rd_crc   <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          mosi_bit <= tx_bit_c;
          wait_cnt <= '0;
          if (bit_cnt == 6'd0) state <= WAIT_R1;
          else                 bit_cnt <= bit_cnt - 6'd1;
        end
        WAIT_R1: begin
          if (!SD_MISO) begin
            shift   <= '0;
            bit_cnt <= 6'd6;
            state   <= RECV_R1;
          end else if (wait_cnt == WAIT_W'(NCR_MAX - 1)) begin
            resp_err <= 1'b1;
            SD_CS    <= 1'b1;
            bit_cnt  <= 6'(TAIL_CYCLES - 1);
            state    <= TAIL;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RECV_R1: begin
          shift <= shift_in_c;
          if (bit_cnt == 6'd0) begin
            resp_r1 <= shift_in_c;
            if (!rd_cmd || shift_in_c != 8'h00) begin
              SD_CS   <= 1'b1;
              bit_cnt <= 6'(TAIL_CYCLES - 1);
              state   <= TAIL;
            end else begin
              shift    <= '1;
              wait_cnt <= '0;
              state    <= WAIT_TOKEN;
            end
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        WAIT_TOKEN: begin
          shift <= shift_in_c;
          if (shift_in_c == SD_TOKEN_START) begin
            bit_cnt  <= 6'd7;
            byte_cnt <= '0;
            state    <= RECV_DATA;
          end else if (wait_cnt == WAIT_W'(TOKEN_MAX - 1)) begin
            resp_err <= 1'b1;
            SD_CS    <= 1'b1;
            bit_cnt  <= 6'(TAIL_CYCLES - 1);
            state    <= TAIL;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RECV_DATA: begin
          shift <= shift_in_c;
          if (bit_cnt == 6'd0) begin
            rd_data  <= shift_in_c;
            rd_valid <= 1'b1;
            if (byte_cnt == 10'(BLK_BYTES - 1)) begin
              rd_last <= 1'b1;
              bit_cnt <= 6'(DATA_CRC_BITS - 1);
              state   <= RECV_CRC;
            end else begin
              byte_cnt <= byte_cnt + 10'd1;
              bit_cnt  <= 6'd7;
            end
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        RECV_CRC: begin
          rd_crc <= {rd_crc[14:0], SD_MISO};
          if (bit_cnt == 6'd0) begin
            SD_CS   <= 1'b1;
            bit_cnt <= 6'(TAIL_CYCLES - 1);
            state   <= TAIL;
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        TAIL: begin
          if (bit_cnt == 6'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
